// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the Mini-SRC datapath.
// The sequencer (master) reads the IR and the start/memory status and drives
// every bus-gating and latch-enable strobe.
interface control_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] IR;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic        MARin, PCin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin;
  logic        IncPC, Read;
  logic [15:0] R0_15_out;
  logic [15:0] R0_15_in;
  logic [4:0]  opcode;
  logic        busy, done, illegal;

  modport master (
    input  start, mem_ready, IR,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
    output MARin, PCin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin,
    output IncPC, Read, R0_15_out, R0_15_in, opcode, busy, done, illegal
  );

  modport slave (
    output start, mem_ready, IR,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
    input  MARin, PCin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin,
    input  IncPC, Read, R0_15_out, R0_15_in, opcode, busy, done, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the Mini-SRC datapath.
// One instruction runs per start: T0..T2 fetch, T3..T5(T6) execute.
// Outputs are decoded from the state register and the IR only; start and
// mem_ready influence nothing but the next state.
module control_sequencer (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  // Instruction op -> ALU operation code (00000 for anything unsupported).
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      5'b00000: alu_code = 5'b00011;
      5'b00001: alu_code = 5'b00100;
      5'b00100: alu_code = 5'b01010;
      5'b00101: alu_code = 5'b01011;
      5'b01111: alu_code = 5'b01110;
      default:  alu_code = 5'b00000;
    endcase
  endfunction

  // True for the ops this sequencer knows how to execute.
  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b01111: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  // Register number -> one-hot 16-bit select.
  function automatic logic [15:0] reg_select(input logic [3:0] idx);
    reg_select = 16'h0001 << idx;
  endfunction

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       t1_first_r;
  logic [4:0] op_s;
  logic [3:0] ra_s, rb_s, rc_s;
  logic       legal_s;
  logic       is_mul_s;

  assign op_s     = bus.IR[31:27];
  assign ra_s     = bus.IR[26:23];
  assign rb_s     = bus.IR[22:19];
  assign rc_s     = bus.IR[18:15];
  assign legal_s  = op_legal(op_s);
  assign is_mul_s = (op_s == 5'b01111);

  // State register; t1_first_r marks the first cycle spent in T1 so the PC
  // is loaded exactly once without making PCin depend on mem_ready.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r    <= S_IDLE;
      t1_first_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      t1_first_r <= (next_state_s == S_T1) && (state_r != S_T1);
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: next_state_s = bus.start ? S_T0 : S_IDLE;
      S_T0:   next_state_s = S_T1;
      S_T1:   next_state_s = bus.mem_ready ? S_T2 : S_T1;
      S_T2:   next_state_s = S_T3;
      S_T3:   next_state_s = legal_s ? S_T4 : S_HALT;
      S_T4:   next_state_s = S_T5;
      S_T5:   next_state_s = is_mul_s ? S_T6 : S_IDLE;
      S_T6:   next_state_s = S_IDLE;
      S_HALT: next_state_s = S_HALT;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Moore output decode: one bus driver per active cycle, all else low.
  always_comb begin
    bus.PCout     = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.MARin     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zhighin   = 1'b0;
    bus.Zlowin    = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.R0_15_out = 16'h0000;
    bus.R0_15_in  = 16'h0000;
    bus.opcode    = 5'b00000;
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    if ((state_r != S_IDLE) && (state_r != S_HALT)) begin
      bus.busy = 1'b1;
    end else begin
      bus.busy = 1'b0;
    end
    case (state_r)
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        bus.PCin    = t1_first_r;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        // An undecodable op leaves T3 silent and heads to HALT.
        if (legal_s) begin
          bus.R0_15_out = reg_select(rb_s);
          bus.Yin       = 1'b1;
        end else begin
          bus.R0_15_out = 16'h0000;
          bus.Yin       = 1'b0;
        end
      end
      S_T4: begin
        bus.R0_15_out = reg_select(rc_s);
        bus.opcode    = alu_code(op_s);
        bus.Zlowin    = 1'b1;
        bus.Zhighin   = is_mul_s;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_mul_s) begin
          bus.LOin = 1'b1;
        end else begin
          bus.R0_15_in = reg_select(ra_s);
          bus.done     = 1'b1;
        end
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
      end
      S_HALT: bus.illegal = 1'b1;
      default: bus.illegal = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fixed instruction vectors with
// hand-computed control patterns, latencies and strobe counts.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic clear;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int drivers();
    return $countones({bus_if.PCout, bus_if.Zhighout, bus_if.Zlowout, bus_if.MDRout,
                       bus_if.HIout, bus_if.LOout, bus_if.R0_15_out});
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0000};
  endfunction

  // advance one clock, then sample 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
    check_eq("bus_onehot", (drivers() <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // load IR and pulse start; returns in T0
  task automatic start_instr(input logic [31:0] ir);
    bus_if.IR    = ir;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  // runs from T0 until done, with a simple memory that withholds
  // mem_ready for 'waits' Read cycles; cycles counts T0 as 1
  task automatic run_done(input int waits, input int max, output int cycles,
                          output int n_pcin, output int n_read, output int n_mdrin,
                          output logic [15:0] rin_or);
    int left;
    left = waits;
    cycles = 1;
    n_pcin = 0;
    n_read = 0;
    n_mdrin = 0;
    rin_or = 16'h0000;
    forever begin
      n_pcin  += int'(bus_if.PCin);
      n_read  += int'(bus_if.Read);
      n_mdrin += int'(bus_if.MDRin);
      rin_or  |= bus_if.R0_15_in;
      if (bus_if.done === 1'b1) break;
      if (cycles >= max) begin
        check_eq("done_timeout", 32'd0, 32'd1);
        break;
      end
      if (bus_if.Read === 1'b1 && left > 0) begin
        bus_if.mem_ready = 1'b0;
        left--;
      end else begin
        bus_if.mem_ready = 1'b1;
      end
      tick();
      cycles++;
    end
    bus_if.mem_ready = 1'b1;
  endtask

  logic [4:0]  tbl_op  [4];
  logic [3:0]  tbl_ra  [4];
  logic [4:0]  tbl_alu [4];
  logic [15:0] tbl_rin [4];

  initial begin
    int cyc, npc, nrd, nmdr, nd, d1, d2;
    logic [15:0] rin;
    logic [15:0] rout_or;

    tbl_op[0] = 5'b00000; tbl_ra[0] = 4'd0;  tbl_alu[0] = 5'b00011; tbl_rin[0] = 16'h0001;
    tbl_op[1] = 5'b00001; tbl_ra[1] = 4'd7;  tbl_alu[1] = 5'b00100; tbl_rin[1] = 16'h0080;
    tbl_op[2] = 5'b00100; tbl_ra[2] = 4'd15; tbl_alu[2] = 5'b01010; tbl_rin[2] = 16'h8000;
    tbl_op[3] = 5'b00101; tbl_ra[3] = 4'd9;  tbl_alu[3] = 5'b01011; tbl_rin[3] = 16'h0200;

    // reset
    clear = 1'b1;
    bus_if.start = 1'b0;
    bus_if.mem_ready = 1'b1;
    bus_if.IR = 32'h0;
    tick();
    tick();
    clear = 1'b0;
    check_eq("rst_busy", bus_if.busy, 1'b0);
    check_eq("rst_done", bus_if.done, 1'b0);
    check_eq("rst_illegal", bus_if.illegal, 1'b0);
    check_eq("rst_opcode", bus_if.opcode, 5'b00000);
    check_eq("rst_rin", bus_if.R0_15_in, 16'h0000);
    tick();
    check_eq("idle_stays", bus_if.busy, 1'b0);

    // or R1,R2,R3, cycle by cycle
    start_instr(32'h28918000);
    check_eq("or_t0", {bus_if.PCout, bus_if.MARin, bus_if.IncPC, bus_if.Zlowin, bus_if.busy}, 5'b11111);
    tick();
    check_eq("or_t1", {bus_if.Read, bus_if.MDRin, bus_if.Zlowout, bus_if.PCin}, 4'b1111);
    tick();
    check_eq("or_t2", {bus_if.MDRout, bus_if.IRin, bus_if.PCin}, 3'b110);
    tick();
    check_eq("or_t3_rout", bus_if.R0_15_out, 16'h0004);
    check_eq("or_t3_yin", bus_if.Yin, 1'b1);
    tick();
    check_eq("or_t4_rout", bus_if.R0_15_out, 16'h0008);
    check_eq("or_t4_opcode", bus_if.opcode, 5'b01011);
    check_eq("or_t4_z", {bus_if.Zlowin, bus_if.Zhighin}, 2'b10);
    tick();
    check_eq("or_t5", {bus_if.Zlowout, bus_if.done}, 2'b11);
    check_eq("or_t5_rin", bus_if.R0_15_in, 16'h0002);
    tick();
    check_eq("or_end", {bus_if.busy, bus_if.done, bus_if.opcode}, 7'b0);

    // decode table, including Ra=0
    for (int i = 0; i < 4; i++) begin
      start_instr(mk_ir(tbl_op[i], tbl_ra[i], 4'd2, 4'd3));
      tick(); tick(); tick(); tick();
      check_eq($sformatf("dec%0d_opcode", i), bus_if.opcode, tbl_alu[i]);
      tick();
      check_eq($sformatf("dec%0d_rin", i), bus_if.R0_15_in, tbl_rin[i]);
      check_eq($sformatf("dec%0d_done", i), bus_if.done, 1'b1);
      tick();
      check_eq($sformatf("dec%0d_idle", i), bus_if.busy, 1'b0);
    end

    // three wait cycles in T1
    start_instr(mk_ir(5'b00000, 4'd1, 4'd2, 4'd3));
    run_done(3, 40, cyc, npc, nrd, nmdr, rin);
    check_eq("wait_latency", cyc, 32'd9);
    check_eq("wait_read_cycles", nrd, 32'd4);
    check_eq("wait_mdrin_cycles", nmdr, 32'd4);
    check_eq("wait_pcin_cycles", npc, 32'd1);
    check_eq("wait_rin", rin, 16'h0002);
    tick();
    check_eq("wait_idle", bus_if.busy, 1'b0);

    // mul R4,R5,R6, cycle by cycle
    start_instr(mk_ir(5'b01111, 4'd4, 4'd5, 4'd6));
    tick(); tick(); tick();
    check_eq("mul_t3_rout", bus_if.R0_15_out, 16'h0020);
    tick();
    check_eq("mul_t4_z", {bus_if.Zlowin, bus_if.Zhighin}, 2'b11);
    check_eq("mul_t4_opcode", bus_if.opcode, 5'b01110);
    check_eq("mul_t4_rout", bus_if.R0_15_out, 16'h0040);
    tick();
    check_eq("mul_t5", {bus_if.Zlowout, bus_if.LOin, bus_if.done, bus_if.HIin}, 4'b1100);
    tick();
    check_eq("mul_t6", {bus_if.Zhighout, bus_if.HIin, bus_if.done, bus_if.Zlowout}, 4'b1110);
    tick();
    check_eq("mul_idle", bus_if.busy, 1'b0);

    // mul latency and no register write
    start_instr(mk_ir(5'b01111, 4'd4, 4'd5, 4'd6));
    run_done(0, 20, cyc, npc, nrd, nmdr, rin);
    check_eq("mul_latency", cyc, 32'd7);
    check_eq("mul_rin", rin, 16'h0000);
    tick();

    // illegal op 11111
    start_instr(mk_ir(5'b11111, 4'd1, 4'd2, 4'd3));
    rout_or = 16'h0000;
    tick(); rout_or |= bus_if.R0_15_out;
    tick(); rout_or |= bus_if.R0_15_out;
    tick(); rout_or |= bus_if.R0_15_out;
    check_eq("ill_t3_yin", bus_if.Yin, 1'b0);
    tick(); rout_or |= bus_if.R0_15_out;
    check_eq("ill_halt", {bus_if.illegal, bus_if.busy, bus_if.done}, 3'b100);
    bus_if.start = 1'b1;
    tick(); rout_or |= bus_if.R0_15_out;
    tick(); rout_or |= bus_if.R0_15_out;
    tick(); rout_or |= bus_if.R0_15_out;
    bus_if.start = 1'b0;
    check_eq("ill_start_ignored", {bus_if.illegal, bus_if.busy, bus_if.PCout}, 3'b100);
    check_eq("ill_no_rout", rout_or, 16'h0000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("ill_cleared", {bus_if.illegal, bus_if.busy}, 2'b00);

    // clear in T4 of an add
    start_instr(mk_ir(5'b00000, 4'd1, 4'd2, 4'd3));
    tick(); tick(); tick(); tick();
    check_eq("clr_pre_opcode", bus_if.opcode, 5'b00011);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_outputs", {bus_if.busy, bus_if.done, bus_if.illegal, bus_if.Zlowin, bus_if.opcode}, 9'b0);
    check_eq("clr_rin", bus_if.R0_15_in, 16'h0000);
    check_eq("clr_rout", bus_if.R0_15_out, 16'h0000);
    tick();
    check_eq("clr_idle", bus_if.busy, 1'b0);

    // back-to-back with start held high
    bus_if.IR = mk_ir(5'b00000, 4'd1, 4'd2, 4'd3);
    bus_if.start = 1'b1;
    nd = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 40 && nd < 2; c++) begin
      tick();
      if (bus_if.done === 1'b1) begin
        if (nd == 0) d1 = c; else d2 = c;
        nd++;
      end
    end
    bus_if.start = 1'b0;
    check_eq("b2b_count", nd, 32'd2);
    check_eq("b2b_first", d1, 32'd6);
    check_eq("b2b_gap", d2 - d1, 32'd7);
    tick();
    tick();
    check_eq("b2b_idle", bus_if.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
